sprite_renderer: RTL and testbench
==================================

SPRITE_RENDERER -- requirements
Module: sprite_renderer

Interface
REQ-001 NUM_SPRITES, default 4: number of independent sprites, 1..8.
REQ-002 SPRITE_W, default 10: sprite width in pixels.
REQ-003 SPRITE_H, default 10: sprite height in pixels.
REQ-004 BORDER_W, default 11: border thickness in pixels; 0 disables the border.
REQ-005 VGA_clk  in  1  pixel clock; the only clock.
REQ-006 reset  in  1  synchronous reset, active-high.
REQ-007 xCount  in  10  current pixel column from the timing generator.
REQ-008 yCount  in  10  current pixel row from the timing generator.
REQ-009 displayArea  in  1  high when the current pixel is in the active region.
REQ-010 pos_wr  in  1  write strobe for the shadow sprite registers.
REQ-011 pos_idx  in  3  sprite index written; index >= NUM_SPRITES is ignored.
REQ-012 pos_x  in  10  new sprite X; pos_y in 9 is the new sprite Y.
REQ-013 pos_vis  in  1  new sprite visible flag.
REQ-014 sprite_rgb  in  3*NUM_SPRITES  per-sprite {R,G,B} colour bits; sprite i uses bits [3i+2:3i].
REQ-015 VGA_R, VGA_G, VGA_B  out  8 each  pixel colour; each channel is all-ones or all-zeros.
REQ-016 collision  out  NUM_SPRITES  per-sprite collision flags for the last completed frame.
REQ-017 collision_valid  out  1  one-cycle pulse when collision is updated.

Function
REQ-018 A pos_wr SHALL update the shadow X/Y/visible of sprite pos_idx on the next VGA_clk edge.
REQ-019 Commit SHALL occur in the cycle where xCount==0 and yCount==480; all shadow values SHALL then be copied to the active set.
REQ-020 A pos_wr in the commit cycle SHALL be included in that commit (write bypass).
REQ-021 Sprite i SHALL cover a pixel iff it is visible, X_i < xCount < X_i+SPRITE_W, and Y_i < yCount < Y_i+SPRITE_H (exclusive bounds).
REQ-022 Bound sums SHALL be computed 11 bits wide; no wrap-around at the right or bottom edge.
REQ-023 Border SHALL cover xCount < BORDER_W, xCount >= 640-BORDER_W, yCount < BORDER_W, or yCount >= 480-BORDER_W.
REQ-024 Priority SHALL be: lowest-index covering sprite, then border (blue), then background (black).
REQ-025 When the pipelined displayArea is low, RGB SHALL be 0.
REQ-026 Latency SHALL be exactly 2 VGA_clk cycles from xCount/yCount/displayArea to RGB; displayArea is delayed to match.
REQ-027 Stage 1 SHALL register the per-sprite hit vector and border flag; stage 2 SHALL register the prioritised colour.

Reset
REQ-028 Reset SHALL clear the shadow and active positions and visibility, the pipeline registers, RGB, collision, collision_valid, and the accumulators.
REQ-029 Reset asserted mid-frame SHALL force RGB to 0 from the next edge; the first commit after reset SHALL proceed normally.

Configuration
REQ-030 Macro SPRITE_COLLISION_EN defined: per-sprite accumulators SHALL set bit i when sprite i and any other sprite cover the same pixel with displayArea high.
REQ-031 With the macro defined, at commit the accumulators SHALL copy to collision, clear, and collision_valid SHALL pulse for 1 cycle.
REQ-032 Macro SPRITE_COLLISION_EN undefined: collision and collision_valid SHALL be tied 0, and no accumulator logic SHALL exist.

Structure
REQ-033 Package sprite_pkg SHALL hold H_ACTIVE=640, V_ACTIVE=480, COMMIT_LINE=480, the X/Y widths, and the BORDER_RGB=3'b001 encoding.
REQ-034 Sub-module sprite_hit SHALL be instantiated once per sprite and perform the single-sprite bound compare (REQ-021/022).

Verification
REQ-035 Sprite 0 written to (100,50), visible, rgb 3'b100; commit; pixel (105,55) -> VGA_R=FF, G=B=00 two cycles later; pixel (100,55) -> black.
REQ-036 Sprites 0 and 1 at (200,200), colours 3'b100 and 3'b010; pixel (205,205) -> red only; next frame: collision=4'b0011 with collision_valid one pulse (macro defined); collision=0 when the macro is undefined.
REQ-037 pos_wr for sprite 2 mid-frame at line 100 -> the displayed position stays unchanged until line 480; the new position is shown from the next frame.
REQ-038 Sprite at X=1020 -> no pixels lit at xCount 0..9 (no wrap); pixel (5,240) -> blue border with BORDER_W=11.
REQ-039 Reset asserted at line 300 for 1 cycle -> RGB=0 from the next edge; collision=0; sprites invisible until a new write and commit.
REQ-040 pos_wr coincident with the commit cycle, pos_idx=1 -> the new value is displayed in the following frame; pos_idx=7 with NUM_SPRITES=4 -> no effect.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared constants for the sprite renderer: screen geometry, coordinate widths, border colour.
// Pure declarations; no logic, no latency, no flow control.
package sprite_pkg;

    localparam int H_ACTIVE    = 640;
    localparam int V_ACTIVE    = 480;
    localparam int COMMIT_LINE = 480;
    localparam int X_W         = 10;
    localparam int Y_W         = 9;
    localparam int CNT_W       = 10;
    localparam int SUM_W       = 11;

    localparam logic [2:0] BORDER_RGB = 3'b001;

    function automatic logic [23:0] expand_rgb(input logic [2:0] c);
        return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
    endfunction

endpackage

// File: rtl/sprite_hit.sv
// Single-sprite coverage test with exclusive bounds, all sums 11 bits so nothing wraps.
// Combinational, zero latency; no flow control.
module sprite_hit
    import sprite_pkg::*;
#(
    parameter int SPRITE_W = 10,
    parameter int SPRITE_H = 10
) (
    input  logic [X_W-1:0]   x_pos,
    input  logic [Y_W-1:0]   y_pos,
    input  logic             vis,
    input  logic [CNT_W-1:0] x_cnt,
    input  logic [CNT_W-1:0] y_cnt,
    output logic             hit
);

    logic [SUM_W-1:0] x_lo;
    logic [SUM_W-1:0] x_hi;
    logic [SUM_W-1:0] y_lo;
    logic [SUM_W-1:0] y_hi;
    logic [SUM_W-1:0] x_c;
    logic [SUM_W-1:0] y_c;

    assign x_lo = SUM_W'(x_pos);
    assign x_hi = SUM_W'(x_pos) + SUM_W'(SPRITE_W);
    assign y_lo = SUM_W'(y_pos);
    assign y_hi = SUM_W'(y_pos) + SUM_W'(SPRITE_H);
    assign x_c  = SUM_W'(x_cnt);
    assign y_c  = SUM_W'(y_cnt);

    assign hit = vis && (x_lo < x_c) && (x_c < x_hi) && (y_lo < y_c) && (y_c < y_hi);

endmodule

// File: rtl/sprite_renderer.sv
// Sprite overlay with double-buffered positions and a blue border; 2-cycle pixel latency, no backpressure.
// Define SPRITE_COLLISION_EN to build the per-frame sprite-overlap detector.
module sprite_renderer
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int SPRITE_W    = 10,
    parameter int SPRITE_H    = 10,
    parameter int BORDER_W    = 11
) (
    input  logic                     VGA_clk,
    input  logic                     reset,
    input  logic [9:0]               xCount,
    input  logic [9:0]               yCount,
    input  logic                     displayArea,
    input  logic                     pos_wr,
    input  logic [2:0]               pos_idx,
    input  logic [9:0]               pos_x,
    input  logic [8:0]               pos_y,
    input  logic                     pos_vis,
    input  logic [3*NUM_SPRITES-1:0] sprite_rgb,
    output logic [7:0]               VGA_R,
    output logic [7:0]               VGA_G,
    output logic [7:0]               VGA_B,
    output logic [NUM_SPRITES-1:0]   collision,
    output logic                     collision_valid
);

    localparam logic [CNT_W-1:0] BW_L    = CNT_W'(BORDER_W);
    localparam logic [CNT_W-1:0] X_LIM_L = CNT_W'(H_ACTIVE - BORDER_W);
    localparam logic [CNT_W-1:0] Y_LIM_L = CNT_W'(V_ACTIVE - BORDER_W);

    logic [X_W-1:0]         sh_x_q  [NUM_SPRITES];
    logic [X_W-1:0]         sh_x_d  [NUM_SPRITES];
    logic [Y_W-1:0]         sh_y_q  [NUM_SPRITES];
    logic [Y_W-1:0]         sh_y_d  [NUM_SPRITES];
    logic [X_W-1:0]         act_x_q [NUM_SPRITES];
    logic [X_W-1:0]         act_x_d [NUM_SPRITES];
    logic [Y_W-1:0]         act_y_q [NUM_SPRITES];
    logic [Y_W-1:0]         act_y_d [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] sh_vis_q, sh_vis_d;
    logic [NUM_SPRITES-1:0] act_vis_q, act_vis_d;

    logic [NUM_SPRITES-1:0] hit_vec;
    logic [NUM_SPRITES-1:0] hit_q, hit_d;
    logic                   border_q, border_d;
    logic                   disp1_q, disp1_d;
    logic [2:0]             rgb_q, rgb_d;
    logic                   commit;

    assign commit = (xCount == CNT_W'(0)) && (yCount == CNT_W'(COMMIT_LINE));

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
        sprite_hit #(
            .SPRITE_W (SPRITE_W),
            .SPRITE_H (SPRITE_H)
        ) u_hit (
            .x_pos (act_x_q[g]),
            .y_pos (act_y_q[g]),
            .vis   (act_vis_q[g]),
            .x_cnt (xCount),
            .y_cnt (yCount),
            .hit   (hit_vec[g])
        );
    end

    always_comb begin
        sh_x_d    = sh_x_q;
        sh_y_d    = sh_y_q;
        sh_vis_d  = sh_vis_q;
        // Out-of-range indices match no slot and are dropped.
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (pos_wr && (pos_idx == 3'(i))) begin
                sh_x_d[i]   = pos_x;
                sh_y_d[i]   = pos_y;
                sh_vis_d[i] = pos_vis;
            end
        end

        act_x_d   = act_x_q;
        act_y_d   = act_y_q;
        act_vis_d = act_vis_q;
        // Copying the _d side lets a write in the commit cycle land in this frame's set.
        if (commit) begin
            act_x_d   = sh_x_d;
            act_y_d   = sh_y_d;
            act_vis_d = sh_vis_d;
        end

        hit_d    = hit_vec;
        disp1_d  = displayArea;
        border_d = (BORDER_W != 0) &&
                   ((xCount < BW_L) || (xCount >= X_LIM_L) ||
                    (yCount < BW_L) || (yCount >= Y_LIM_L));

        rgb_d = 3'b000;
        if (disp1_q) begin
            if (border_q) begin
                rgb_d = BORDER_RGB;
            end
            for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
                if (hit_q[i]) begin
                    rgb_d = sprite_rgb[3*i +: 3];
                end
            end
        end
    end

    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                sh_x_q[i]  <= '0;
                sh_y_q[i]  <= '0;
                act_x_q[i] <= '0;
                act_y_q[i] <= '0;
            end
            sh_vis_q  <= '0;
            act_vis_q <= '0;
            hit_q     <= '0;
            border_q  <= 1'b0;
            disp1_q   <= 1'b0;
            rgb_q     <= 3'b000;
        end else begin
            sh_x_q    <= sh_x_d;
            sh_y_q    <= sh_y_d;
            sh_vis_q  <= sh_vis_d;
            act_x_q   <= act_x_d;
            act_y_q   <= act_y_d;
            act_vis_q <= act_vis_d;
            hit_q     <= hit_d;
            border_q  <= border_d;
            disp1_q   <= disp1_d;
            rgb_q     <= rgb_d;
        end
    end

    assign {VGA_R, VGA_G, VGA_B} = expand_rgb(rgb_q);

`ifdef SPRITE_COLLISION_EN
    logic [NUM_SPRITES-1:0] acc_q, acc_d;
    logic [NUM_SPRITES-1:0] coll_q, coll_d;
    logic [NUM_SPRITES-1:0] overlap;
    logic                   cv_q, cv_d;

    always_comb begin
        overlap = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            overlap[i] = disp1_q && hit_q[i] &&
                         ((hit_q & ~(NUM_SPRITES'(1) << i)) != '0);
        end
        acc_d  = acc_q | overlap;
        coll_d = coll_q;
        cv_d   = 1'b0;
        if (commit) begin
            coll_d = acc_q | overlap;
            acc_d  = '0;
            cv_d   = 1'b1;
        end
    end

    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            acc_q  <= '0;
            coll_q <= '0;
            cv_q   <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            coll_q <= coll_d;
            cv_q   <= cv_d;
        end
    end

    assign collision       = coll_q;
    assign collision_valid = cv_q;
`else
    assign collision       = '0;
    assign collision_valid = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_renderer.sv
// Scoreboard bench for sprite_renderer: expected pixels queued at drive time, compared two cycles later.
module tb_sprite_renderer;

    localparam int NS = 4;
`ifdef SPRITE_COLLISION_EN
    localparam bit COLL_EN = 1'b1;
`else
    localparam bit COLL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [9:0]    xCount = '0;
    logic [9:0]    yCount = '0;
    logic          displayArea = 1'b0;
    logic          pos_wr = 1'b0;
    logic [2:0]    pos_idx = '0;
    logic [9:0]    pos_x = '0;
    logic [8:0]    pos_y = '0;
    logic          pos_vis = 1'b0;
    logic [11:0]   sprite_rgb = {3'b011, 3'b110, 3'b010, 3'b100};
    logic [7:0]    VGA_R, VGA_G, VGA_B;
    logic [NS-1:0] collision;
    logic          collision_valid;

    always #5 clk = ~clk;

    sprite_renderer #(
        .NUM_SPRITES (NS),
        .SPRITE_W    (10),
        .SPRITE_H    (10),
        .BORDER_W    (11)
    ) dut (
        .VGA_clk         (clk),
        .reset           (reset),
        .xCount          (xCount),
        .yCount          (yCount),
        .displayArea     (displayArea),
        .pos_wr          (pos_wr),
        .pos_idx         (pos_idx),
        .pos_x           (pos_x),
        .pos_y           (pos_y),
        .pos_vis         (pos_vis),
        .sprite_rgb      (sprite_rgb),
        .VGA_R           (VGA_R),
        .VGA_G           (VGA_G),
        .VGA_B           (VGA_B),
        .collision       (collision),
        .collision_valid (collision_valid)
    );

    typedef struct {
        logic        chk;
        logic [23:0] rgb;
        int          x;
        int          y;
    } exp_t;

    exp_t exp_q[$];
    exp_t pop_e;
    int   n_cmp = 0;
    int   n_err = 0;

    int      m_sh_x [NS];
    int      m_sh_y [NS];
    bit      m_sh_v [NS];
    int      m_act_x[NS];
    int      m_act_y[NS];
    bit      m_act_v[NS];
    logic [NS-1:0] m_acc = '0;
    logic [NS-1:0] m_coll = '0;

    bit nxt_wr = 0;
    int nxt_idx = 0;
    int nxt_x = 0;
    int nxt_y = 0;
    bit nxt_vis = 0;
    bit nxt_rst = 0;

    int            cv_cnt = 0;
    logic [NS-1:0] cv_val = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NS-1:0] model_hits(int x, int y);
        logic [NS-1:0] h = '0;
        for (int i = 0; i < NS; i++)
            h[i] = m_act_v[i] && (m_act_x[i] < x) && (x < m_act_x[i] + 10) &&
                   (m_act_y[i] < y) && (y < m_act_y[i] + 10);
        return h;
    endfunction

    function automatic logic [23:0] model_px(int x, int y, bit d);
        logic [2:0]    c = 3'b000;
        logic [NS-1:0] h;
        if (!d) return 24'h0;
        if (x < 11 || x >= 629 || y < 11 || y >= 469) c = 3'b001;
        h = model_hits(x, y);
        for (int i = NS - 1; i >= 0; i--)
            if (h[i]) c = sprite_rgb[3*i +: 3];
        return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
    endfunction

    task automatic set_wr(input int idx, input int x, input int y, input bit v);
        nxt_wr = 1; nxt_idx = idx; nxt_x = x; nxt_y = y; nxt_vis = v;
    endtask

    // One pixel cycle: drive inputs, update the reference model, queue the expected output.
    task automatic cyc(input int x, input int y, input bit d, input bit chk);
        exp_t          e;
        exp_t          prev;
        logic [NS-1:0] h;
        xCount = 10'(x); yCount = 10'(y); displayArea = d;
        pos_wr = nxt_wr; pos_idx = 3'(nxt_idx); pos_x = 10'(nxt_x);
        pos_y = 9'(nxt_y); pos_vis = nxt_vis; reset = nxt_rst;
        e.chk = chk; e.x = x; e.y = y;
        if (nxt_rst) begin
            e.rgb = 24'h0;
            if (exp_q.size() > 0) begin
                prev = exp_q[exp_q.size()-1];
                prev.rgb = 24'h0;
                exp_q[exp_q.size()-1] = prev;
            end
            for (int i = 0; i < NS; i++) begin
                m_sh_x[i] = 0; m_sh_y[i] = 0; m_sh_v[i] = 0;
                m_act_x[i] = 0; m_act_y[i] = 0; m_act_v[i] = 0;
            end
            m_acc = '0; m_coll = '0;
        end else begin
            e.rgb = model_px(x, y, d);
            h = model_hits(x, y);
            if (nxt_wr && nxt_idx < NS) begin
                m_sh_x[nxt_idx] = nxt_x; m_sh_y[nxt_idx] = nxt_y; m_sh_v[nxt_idx] = nxt_vis;
            end
            if (x == 0 && y == 480) begin
                m_act_x = m_sh_x; m_act_y = m_sh_y; m_act_v = m_sh_v;
                m_coll = m_acc; m_acc = '0;
            end
            if (d && $countones(h) >= 2) m_acc = m_acc | h;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        nxt_wr = 0; nxt_rst = 0; pos_wr = 0; reset = 0;
    endtask

    always begin
        @(posedge clk);
        #2;
        if (exp_q.size() >= 3) begin
            pop_e = exp_q.pop_front();
            if (pop_e.chk)
                check_eq($sformatf("rgb(%0d,%0d)", pop_e.x, pop_e.y),
                         {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, pop_e.rgb});
        end
    end

    always begin
        @(posedge clk);
        #2;
        if (collision_valid === 1'b1) begin
            cv_cnt++;
            cv_val = collision;
        end
    end

    initial begin
        for (int i = 0; i < NS; i++) begin
            m_sh_x[i] = 0; m_sh_y[i] = 0; m_sh_v[i] = 0;
            m_act_x[i] = 0; m_act_y[i] = 0; m_act_v[i] = 0;
        end
        @(posedge clk);
        #1;

        // Reset state, then border/background/blanking boundaries.
        repeat (3) begin nxt_rst = 1; cyc(5, 240, 1, 1); end
        check_eq("coll_after_reset", 32'(collision), 32'h0);
        check_eq("cv_after_reset", 32'(collision_valid), 32'h0);
        cyc(5, 240, 1, 1);
        cyc(320, 240, 1, 1);
        cyc(320, 240, 0, 1);
        cyc(5, 240, 0, 1);
        cyc(10, 240, 1, 1);
        cyc(11, 240, 1, 1);
        cyc(628, 240, 1, 1);
        cyc(629, 240, 1, 1);
        cyc(320, 468, 1, 1);
        cyc(320, 469, 1, 1);

        // Single sprite, shown only after commit, exclusive edges.
        set_wr(0, 100, 50, 1); cyc(320, 240, 1, 1);
        cyc(105, 55, 1, 1);
        cyc(0, 480, 0, 1);
        cyc(105, 55, 1, 1);
        cyc(100, 55, 1, 1);
        cyc(109, 59, 1, 1);
        cyc(110, 55, 1, 1);
        cyc(105, 50, 1, 1);
        cyc(105, 51, 1, 1);

        // Two overlapping sprites: priority and collision report.
        set_wr(1, 200, 200, 1); cyc(320, 240, 1, 1);
        set_wr(0, 200, 200, 1); cyc(320, 240, 1, 1);
        cyc(0, 480, 0, 1);
        cyc(205, 205, 1, 1);
        cyc(201, 201, 1, 1);
        cyc(205, 205, 0, 1);
        cyc(209, 209, 1, 1);
        cyc(210, 205, 1, 1);
        cv_cnt = 0;
        cyc(0, 480, 0, 1);
        cyc(320, 240, 0, 0);
        cyc(320, 240, 0, 0);
        check_eq("coll_pulses", 32'(cv_cnt), COLL_EN ? 32'd1 : 32'd0);
        check_eq("coll_value", 32'(collision), COLL_EN ? 32'(m_coll) : 32'h0);
        check_eq("coll_value_nonzero_model", 32'(m_coll != 0), 32'd1);

        // Mid-frame move stays hidden until the next commit.
        set_wr(2, 400, 300, 1); cyc(320, 240, 1, 1);
        cyc(0, 480, 0, 1);
        cyc(405, 305, 1, 1);
        set_wr(2, 300, 100, 1); cyc(50, 100, 1, 1);
        cyc(305, 105, 1, 1);
        cyc(405, 305, 1, 1);
        cyc(0, 480, 0, 1);
        cyc(305, 105, 1, 1);
        cyc(405, 305, 1, 1);

        // Sprite near X=1023 must not wrap into the left columns.
        set_wr(3, 1020, 240, 1); cyc(320, 240, 1, 1);
        cyc(0, 480, 0, 1);
        for (int x = 0; x < 10; x++) cyc(x, 245, 1, 1);
        cyc(5, 240, 1, 1);

        // Writes in the commit cycle: in-range bypasses, out-of-range is dropped.
        set_wr(1, 500, 400, 1); cyc(0, 480, 0, 1);
        cyc(505, 405, 1, 1);
        set_wr(7, 600, 50, 1); cyc(0, 480, 0, 1);
        cyc(605, 55, 1, 1);
        cyc(505, 405, 1, 1);

        // Mid-frame reset at line 300.
        cyc(5, 300, 1, 1);
        cyc(5, 300, 1, 1);
        nxt_rst = 1; cyc(5, 300, 1, 1);
        cyc(5, 300, 1, 1);
        cyc(505, 405, 1, 1);
        cyc(205, 205, 1, 1);
        check_eq("coll_after_midreset", 32'(collision), 32'h0);
        set_wr(0, 100, 50, 1); cyc(105, 55, 1, 1);
        cyc(105, 55, 1, 1);
        cyc(0, 480, 0, 1);
        cyc(105, 55, 1, 1);

        repeat (3) cyc(0, 0, 0, 0);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
